// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
// Shared definitions for the bit-serial magnitude comparator:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - two-bit present-state result codes carried from cell to cell
//   - small helper used when deciding whether a comparison is settled
// -----------------------------------------------------------------------------
package comparador_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Present-state codes; RES_EQ must stay all-zero so a cleared register
   // reads as "no difference seen yet".
   localparam logic [1:0] RES_EQ = 2'b00;
   localparam logic [1:0] RES_GT = 2'b01;
   localparam logic [1:0] RES_LT = 2'b10;

   // True once a present-state code carries a strict ordering.
   function automatic logic res_decided(input logic [1:0] p);
      logic r;
      if (p != RES_EQ) begin
         r = 1'b1;
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

endpackage : comparador_pkg

// File: rtl/celda_serial.sv
// -----------------------------------------------------------------------------
// celda_serial
// Purely combinational comparator bit-cell.
// Ports:
//   p          [1:0] present state (RES_EQ / RES_GT / RES_LT)
//   a, b             operand bits of the current position
//   lock_first       1: first difference locks the result (MSB-first scan)
//                    0: every difference overrides (LSB-first scan)
//   p_next     [1:0] next present state
// -----------------------------------------------------------------------------
module celda_serial
   import comparador_pkg::*;
(
   input  logic [1:0] p,
   input  logic       a,
   input  logic       b,
   input  logic       lock_first,
   output logic [1:0] p_next
);

   logic differ_s;
   logic may_update_s;

   // A difference only counts if no earlier one has locked the result.
   always_comb begin
      differ_s     = a ^ b;
      may_update_s = 1'b0;
      if (lock_first) begin
         may_update_s = (p == RES_EQ) ? 1'b1 : 1'b0;
      end else begin
         may_update_s = 1'b1;
      end
   end

   // Cell rule: a differing bit pair sets the ordering by the A bit.
   always_comb begin
      p_next = p;
      if (differ_s && may_update_s) begin
         p_next = a ? RES_GT : RES_LT;
      end else begin
         p_next = p;
      end
   end

endmodule : celda_serial

// File: rtl/comparador_serial.sv
// -----------------------------------------------------------------------------
// comparador_serial
// Bit-serial magnitude comparator: one bit pair per clock, scanning either
// LSB-first (MSB_FIRST = 0) or MSB-first (MSB_FIRST = 1).
// Optional macro COMPARADOR_EARLY_EXIT_EN: with MSB_FIRST = 1 the run ends
// on the first differing bit; it has no effect for LSB-first scans.
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            request; accepted only in IDLE
//   A, B     [N-1:0] operands, captured on the accepted start edge
//   busy             high while bits are being consumed
//   done             one-cycle pulse when gt/eq/lt/Z become valid
//   gt, eq, lt       three-way result (one-hot while valid)
//   Z                A >= B
// -----------------------------------------------------------------------------
module comparador_serial
   import comparador_pkg::*;
#(
   parameter int N         = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         gt,
   output logic         eq,
   output logic         lt,
   output logic         Z
);

   localparam int            CW        = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(N);
   localparam logic          LOCK_MODE = (MSB_FIRST != 0) ? 1'b1 : 1'b0;

   state_t        state_r;
   state_t        state_next_s;
   logic [N-1:0]  a_sh_r;
   logic [N-1:0]  b_sh_r;
   logic [N-1:0]  a_shift_s;
   logic [N-1:0]  b_shift_s;
   logic [1:0]    p_r;
   logic [1:0]    p_next_s;
   logic [CW-1:0] cnt_r;
   logic          a_bit_s;
   logic          b_bit_s;
   logic          last_bit_s;
   logic          early_s;
   logic          finish_s;
   logic          accept_s;
   logic          busy_r;
   logic          done_r;
   logic          gt_r;
   logic          eq_r;
   logic          lt_r;
   logic          z_r;

   celda_serial u_celda (
      .p          (p_r),
      .a          (a_bit_s),
      .b          (b_bit_s),
      .lock_first (LOCK_MODE),
      .p_next     (p_next_s)
   );

   // Pick the bit pair at the scan end and prepare the shifted operands.
   always_comb begin
      a_bit_s   = 1'b0;
      b_bit_s   = 1'b0;
      a_shift_s = a_sh_r;
      b_shift_s = b_sh_r;
      if (LOCK_MODE) begin
         a_bit_s   = a_sh_r[N-1];
         b_bit_s   = b_sh_r[N-1];
         a_shift_s = {a_sh_r[N-2:0], 1'b0};
         b_shift_s = {b_sh_r[N-2:0], 1'b0};
      end else begin
         a_bit_s   = a_sh_r[0];
         b_bit_s   = b_sh_r[0];
         a_shift_s = {1'b0, a_sh_r[N-1:1]};
         b_shift_s = {1'b0, b_sh_r[N-1:1]};
      end
   end

`ifdef COMPARADOR_EARLY_EXIT_EN
   // MSB-first: once the ordering is locked the remaining bits cannot change it.
   always_comb begin
      if (LOCK_MODE && res_decided(p_next_s)) begin
         early_s = 1'b1;
      end else begin
         early_s = 1'b0;
      end
   end
`else
   assign early_s = 1'b0;
`endif

   // Run-termination and start-acceptance conditions.
   always_comb begin
      last_bit_s = (cnt_r == CNT_LAST) ? 1'b1 : 1'b0;
      finish_s   = (state_r == ST_RUN) && (last_bit_s || early_s);
      accept_s   = (state_r == ST_IDLE) && start;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (finish_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Datapath: operand shift registers, present state and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r <= '0;
         b_sh_r <= '0;
         p_r    <= RES_EQ;
         cnt_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  a_sh_r <= A;
                  b_sh_r <= B;
                  p_r    <= RES_EQ;
                  cnt_r  <= '0;
               end else begin
                  a_sh_r <= a_sh_r;
                  b_sh_r <= b_sh_r;
                  p_r    <= p_r;
                  cnt_r  <= cnt_r;
               end
            end
            ST_RUN: begin
               a_sh_r <= a_shift_s;
               b_sh_r <= b_shift_s;
               p_r    <= p_next_s;
               // Saturate at N; the counter never wraps.
               if (cnt_r != CNT_MAX) begin
                  cnt_r <= cnt_r + CW'(1);
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            default: begin
               a_sh_r <= a_sh_r;
               b_sh_r <= b_sh_r;
               p_r    <= p_r;
               cnt_r  <= cnt_r;
            end
         endcase
      end
   end

   // Registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         gt_r   <= 1'b0;
         eq_r   <= 1'b0;
         lt_r   <= 1'b0;
         z_r    <= 1'b0;
      end else begin
         busy_r <= (state_next_s == ST_RUN) ? 1'b1 : 1'b0;
         done_r <= finish_s;
         if (accept_s) begin
            // A new comparison invalidates the previous result.
            gt_r <= 1'b0;
            eq_r <= 1'b0;
            lt_r <= 1'b0;
            z_r  <= 1'b0;
         end else if (finish_s) begin
            gt_r <= (p_next_s == RES_GT) ? 1'b1 : 1'b0;
            eq_r <= (p_next_s == RES_EQ) ? 1'b1 : 1'b0;
            lt_r <= (p_next_s == RES_LT) ? 1'b1 : 1'b0;
            z_r  <= (p_next_s != RES_LT) ? 1'b1 : 1'b0;
         end else begin
            gt_r <= gt_r;
            eq_r <= eq_r;
            lt_r <= lt_r;
            z_r  <= z_r;
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign gt   = gt_r;
   assign eq   = eq_r;
   assign lt   = lt_r;
   assign Z    = z_r;

endmodule : comparador_serial

// File: tb/tb_comparador_serial.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial
// Four instances: N=8 LSB-first (0), N=8 MSB-first (1), N=4 LSB-first (2),
// N=4 MSB-first (3). Expected results come from integer comparison of the
// operands; expected latency from the position of the first differing bit.
// -----------------------------------------------------------------------------
module tb_comparador_serial;

`ifdef COMPARADOR_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] start_v = 4'b0000;
   logic [7:0] a8 = 8'h00;
   logic [7:0] b8 = 8'h00;
   logic [3:0] a4 = 4'h0;
   logic [3:0] b4 = 4'h0;
   logic [3:0] busy_v, done_v, gt_v, eq_v, lt_v, z_v;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   comparador_serial #(.N(8), .MSB_FIRST(0)) d8l (
      .clk(clk), .rst(rst), .start(start_v[0]), .A(a8), .B(b8),
      .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]),
      .lt(lt_v[0]), .Z(z_v[0]));
   comparador_serial #(.N(8), .MSB_FIRST(1)) d8m (
      .clk(clk), .rst(rst), .start(start_v[1]), .A(a8), .B(b8),
      .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]),
      .lt(lt_v[1]), .Z(z_v[1]));
   comparador_serial #(.N(4), .MSB_FIRST(0)) d4l (
      .clk(clk), .rst(rst), .start(start_v[2]), .A(a4), .B(b4),
      .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]),
      .lt(lt_v[2]), .Z(z_v[2]));
   comparador_serial #(.N(4), .MSB_FIRST(1)) d4m (
      .clk(clk), .rst(rst), .start(start_v[3]), .A(a4), .B(b4),
      .busy(busy_v[3]), .done(done_v[3]), .gt(gt_v[3]), .eq(eq_v[3]),
      .lt(lt_v[3]), .Z(z_v[3]));

   typedef struct {
      int         dut;
      logic [7:0] a;
      logic [7:0] b;
      logic       gt;
      logic       eq;
      logic       lt;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic int width_of(input int d);
      return (d < 2) ? 8 : 4;
   endfunction

   // Cycles from start edge to done edge.
   function automatic int model_lat(input int d, input logic [7:0] a, input logic [7:0] b);
      int  n;
      bit  msb;
      n   = width_of(d);
      msb = (d == 1) || (d == 3);
      if (!(msb && EARLY) || (a == b)) return n;
      for (int i = n - 1; i >= 0; i--) begin
         if (a[i] != b[i]) return n - i;
      end
      return n;
   endfunction

   // One full comparison; leaves the bench on a negedge with the DUT idle.
   task automatic run_cmp(input int d, input logic [7:0] a_in, input logic [7:0] b_in,
                          input logic egt, input logic eeq, input logic elt, input string tag);
      int lat;
      int busy_cyc;
      int exp_lat;
      int n;
      n       = width_of(d);
      exp_lat = model_lat(d, a_in, b_in);
      a8 = a_in; b8 = b_in; a4 = a_in[3:0]; b4 = b_in[3:0];
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy_v[d]), 32'd1);
      chk({tag, "_cleared"}, 32'({gt_v[d], eq_v[d], lt_v[d], z_v[d]}), 32'd0);
      lat = 0;
      busy_cyc = 0;
      while (done_v[d] !== 1'b1 && lat < 2 * n + 4) begin
         if (busy_v[d] === 1'b1) busy_cyc++;
         a8 = ~a8; b8 = ~b8; a4 = ~a4; b4 = ~b4;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
      chk({tag, "_busy_at_done"}, 32'(busy_v[d]), 32'd0);
      chk({tag, "_result"}, 32'({gt_v[d], eq_v[d], lt_v[d], z_v[d]}),
          32'({egt, eeq, elt, egt | eeq}));
      chk({tag, "_onehot"}, 32'(gt_v[d]) + 32'(eq_v[d]) + 32'(lt_v[d]), 32'd1);
      @(negedge clk);
      chk({tag, "_done_fall"}, 32'(done_v[d]), 32'd0);
      chk({tag, "_hold"}, 32'({gt_v[d], eq_v[d], lt_v[d], z_v[d]}),
          32'({egt, eeq, elt, egt | eeq}));
   endtask

   task automatic run_model(input int d, input logic [7:0] a_in, input logic [7:0] b_in,
                            input string tag);
      logic [7:0] am, bm;
      am = (d < 2) ? a_in : (a_in & 8'h0F);
      bm = (d < 2) ? b_in : (b_in & 8'h0F);
      run_cmp(d, am, bm, am > bm, am == bm, am < bm, tag);
   endtask

   initial begin
      int pulses;
      bit seen;

      tbl[0] = '{0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy_v), 32'd0);
      chk("reset_done", 32'(done_v), 32'd0);
      chk("reset_result", 32'({gt_v, eq_v, lt_v, z_v}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 8; i++) begin
         run_cmp(tbl[i].dut, tbl[i].a, tbl[i].b, tbl[i].gt, tbl[i].eq, tbl[i].lt,
                 $sformatf("tbl%0d", i));
      end

      // Start held high through RUN/DONE with operands toggling
      a8 = 8'h80; b8 = 8'h7F;
      start_v[0] = 1'b1;
      pulses = 0;
      seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) begin
            pulses++;
            if (!seen) begin
               chk("hold_result", 32'({gt_v[0], eq_v[0], lt_v[0], z_v[0]}), 32'b1001);
               seen = 1'b1;
            end
            start_v[0] = 1'b0;
         end
         a8 = ~a8; b8 = ~b8;
      end
      start_v[0] = 1'b0;
      chk("hold_pulses", 32'(pulses), 32'd1);

      // Reset in the middle of a run
      a8 = 8'h5A; b8 = 8'h5A;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy_v[0]), 32'd0);
      chk("abort_done", 32'(done_v[0]), 32'd0);
      chk("abort_result", 32'({gt_v[0], eq_v[0], lt_v[0], z_v[0]}), 32'd0);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) pulses++;
      end
      chk("abort_quiet", 32'(pulses), 32'd0);
      run_cmp(0, 8'hC3, 8'h3C, 1'b1, 1'b0, 1'b0, "after_abort");

      // Random operands on the 8-bit instances
      for (int i = 0; i < 40; i++) begin
         run_model(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   $sformatf("rnd%0d", i));
      end

      // Exhaustive 4-bit pairs, back to back, both scan directions
      for (int d = 2; d < 4; d++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               run_model(d, 8'(a), 8'(b), $sformatf("exh_d%0d_%0h_%0h", d, a, b));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_comparador_serial
